// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode stage. Valid/ready on both
// sides, with a main output register backed by a one-entry skid register.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_INV = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  state_e     state_q, state_d;
  dec_t       main_q, main_d;
  dec_t       skid_q, skid_d;
  dec_t       dec_in;
  logic       acc, pop;
  logic       load_main_in, load_main_skid, load_skid;
  logic [6:0] opcode;
  logic [2:0] fmt;
  logic       illegal;
  logic [31:0] imm32;

  // Decode the incoming word; illegal encodings keep only opcode and pc.
  always_comb begin
    opcode = in_instr[6:0];
    case (opcode)
      7'b0110011:                         fmt = FMT_R;
      7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1101111:                         fmt = FMT_J;
      default:                            fmt = FMT_INV;
    endcase
    illegal = (in_instr[1:0] != 2'b11) || (fmt == FMT_INV)
           || ((fmt == FMT_R) && (in_instr[31:25] != 7'b0000000) && (in_instr[31:25] != 7'b0100000))
           || ((opcode == 7'b1100111) && (in_instr[14:12] != 3'b000))
           || ((fmt == FMT_B) && (in_instr[14:13] == 2'b01));
    case (fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = 32'b0;
    endcase
    dec_in        = '0;
    dec_in.pc     = in_pc;
    dec_in.opcode = opcode;
    if (illegal) begin
      dec_in.fmt     = FMT_INV;
      dec_in.illegal = 1'b1;
    end else begin
      dec_in.fmt = fmt;
      dec_in.imm = XLEN'($signed(imm32));
      if (fmt != FMT_S && fmt != FMT_B) dec_in.rd = in_instr[11:7];
      if (fmt != FMT_U && fmt != FMT_J) begin
        dec_in.rs1    = in_instr[19:15];
        dec_in.funct3 = in_instr[14:12];
      end
      if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) dec_in.rs2 = in_instr[24:20];
      if (fmt == FMT_R) dec_in.funct7 = in_instr[31:25];
    end
  end

  // State register; reset leaves the stage empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over any same-cycle handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (acc) state_d = ONE;
        ONE: begin
          if (acc && !pop)      state_d = FULL;
          else if (!acc && pop) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs from registered state only, plus register load enables.
  always_comb begin
    in_ready       = (state_q != FULL);
    out_valid      = (state_q != EMPTY);
    acc            = in_valid && in_ready;
    pop            = out_valid && out_ready;
    load_main_in   = !flush && acc && (state_q == EMPTY || pop);
    load_skid      = !flush && acc && (state_q == ONE) && !pop;
    load_main_skid = !flush && pop && (state_q == FULL);
  end

  // Next values of the main and skid registers.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main_in)   main_d = dec_in;
    if (load_main_skid) main_d = skid_q;
    if (load_skid)      skid_d = dec_in;
  end

  // Data registers; cleared on reset so every output field reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Output fields come straight from the main register.
  always_comb begin
    out_pc      = main_q.pc;
    out_opcode  = main_q.opcode;
    out_rd      = main_q.rd;
    out_rs1     = main_q.rs1;
    out_rs2     = main_q.rs2;
    out_funct3  = main_q.funct3;
    out_funct7  = main_q.funct7;
    out_imm     = main_q.imm;
    out_fmt     = main_q.fmt;
    out_illegal = main_q.illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives a 64-bit and a 32-bit decode_stage with the same
// stimulus and checks both against a queue-based reference model.
module tb_decode_stage;

  typedef struct {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_pc64, out_imm64;
  logic [6:0]  out_opcode64, out_funct7_64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic [2:0]  out_funct3_64, out_fmt64;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_pc32, out_imm32;
  logic [6:0]  out_opcode32, out_funct7_32;
  logic [4:0]  out_rd32, out_rs1_32, out_rs2_32;
  logic [2:0]  out_funct3_32, out_fmt32;

  int   testCount = 0;
  int   failCount = 0;
  exp_t q[$];
  logic lastAcc = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs1_64),
    .out_rs2(out_rs2_64), .out_funct3(out_funct3_64), .out_funct7(out_funct7_64),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .out_pc(out_pc32), .out_opcode(out_opcode32), .out_rd(out_rd32), .out_rs1(out_rs1_32),
    .out_rs2(out_rs2_32), .out_funct3(out_funct3_32), .out_funct7(out_funct7_32),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32)
  );

  // Reference decode: field rules per format, immediates by two's-complement arithmetic.
  function automatic exp_t modelDecode(input logic [31:0] ins, input logic [63:0] pc);
    exp_t        e;
    int          f;
    logic [6:0]  op;
    logic        bad;
    logic [63:0] v;
    op = ins[6:0];
    e.pc = pc; e.opcode = op; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    e.funct3 = 0; e.funct7 = 0; e.imm = 0; e.fmt = 0; e.illegal = 0;
    case (op)
      7'b0110011:                         f = 0;
      7'b0000011, 7'b0010011, 7'b1100111: f = 1;
      7'b0100011:                         f = 2;
      7'b1100011:                         f = 3;
      7'b0110111, 7'b0010111:             f = 4;
      7'b1101111:                         f = 5;
      default:                            f = 7;
    endcase
    bad = (ins[1:0] != 2'b11) || (f == 7)
       || (f == 0 && ins[31:25] != 7'd0 && ins[31:25] != 7'h20)
       || (op == 7'b1100111 && ins[14:12] != 3'd0)
       || (f == 3 && (ins[14:12] == 3'd2 || ins[14:12] == 3'd3));
    if (bad) begin
      e.fmt = 3'd7;
      e.illegal = 1'b1;
      return e;
    end
    e.fmt = 3'(f);
    if (f == 0 || f == 1 || f == 4 || f == 5) e.rd = ins[11:7];
    if (f <= 3) begin e.rs1 = ins[19:15]; e.funct3 = ins[14:12]; end
    if (f == 0 || f == 2 || f == 3) e.rs2 = ins[24:20];
    if (f == 0) e.funct7 = ins[31:25];
    v = 0;
    case (f)
      1: begin v = 64'(ins[31:20]); if (ins[31]) v = v - 64'd4096; end
      2: begin v = 64'({ins[31:25], ins[11:7]}); if (ins[31]) v = v - 64'd4096; end
      3: begin v = 64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); if (ins[31]) v = v - 64'd8192; end
      4: begin v = 64'(ins[31:12]) * 64'd4096; if (ins[31]) v = v - 64'h1_0000_0000; end
      5: begin v = 64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); if (ins[31]) v = v - 64'h20_0000; end
      default: v = 0;
    endcase
    e.imm = v;
    return e;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checkVal("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    checkVal("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    checkVal("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    checkVal("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
    if (q.size() > 0) begin
      e = q[0];
      checkVal("pc64", out_pc64, e.pc);
      checkVal("opcode64", 64'(out_opcode64), 64'(e.opcode));
      checkVal("rd64", 64'(out_rd64), 64'(e.rd));
      checkVal("rs1_64", 64'(out_rs1_64), 64'(e.rs1));
      checkVal("rs2_64", 64'(out_rs2_64), 64'(e.rs2));
      checkVal("funct7_64", 64'(out_funct7_64), 64'(e.funct7));
      checkVal("imm64", out_imm64, e.imm);
      checkVal("fmt64", 64'(out_fmt64), 64'(e.fmt));
      checkVal("illegal64", 64'(out_illegal64), 64'(e.illegal));
      checkVal("pc32", 64'(out_pc32), 64'(e.pc[31:0]));
      checkVal("opcode32", 64'(out_opcode32), 64'(e.opcode));
      checkVal("rd32", 64'(out_rd32), 64'(e.rd));
      checkVal("rs1_32", 64'(out_rs1_32), 64'(e.rs1));
      checkVal("rs2_32", 64'(out_rs2_32), 64'(e.rs2));
      checkVal("funct7_32", 64'(out_funct7_32), 64'(e.funct7));
      checkVal("imm32", 64'(out_imm32), 64'(e.imm[31:0]));
      checkVal("fmt32", 64'(out_fmt32), 64'(e.fmt));
      checkVal("illegal32", 64'(out_illegal32), 64'(e.illegal));
      if (!e.illegal) begin
        checkVal("funct3_64", 64'(out_funct3_64), 64'(e.funct3));
        checkVal("funct3_32", 64'(out_funct3_32), 64'(e.funct3));
      end
    end
  endtask

  // One clock cycle: drive inputs, check current outputs, advance, update the model.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                               input logic rdy, input logic fl);
    logic expAcc, expPop;
    exp_t dropped;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
    checkOutput();
    expAcc = v && (q.size() < 2);
    expPop = (q.size() > 0) && rdy;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (expPop) dropped = q.pop_front();
      if (expAcc) q.push_back(modelDecode(ins, pc));
    end
    lastAcc = expAcc;
  endtask

  initial begin
    logic        sent;
    logic [31:0] r;
    logic [31:0] ins;
    logic [6:0]  ops [10];
    int          sel;
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

    // Reset state
    #2;
    checkVal("rst_out_valid", 64'(out_valid64), 64'd0);
    checkVal("rst_in_ready", 64'(in_ready64), 64'd1);
    checkVal("rst_out_pc", out_pc64, 64'd0);
    checkVal("rst_out_imm", out_imm64, 64'd0);
    checkVal("rst_out_fmt", 64'(out_fmt64), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // addi x1,x2,-1
    applyStimulus(1, 32'hFFF10093, 64'h100, 1, 0);
    checkVal("addi_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    checkVal("addi_imm32", 64'(out_imm32), 64'h0000_0000_FFFF_FFFF);
    checkVal("addi_rd", 64'(out_rd64), 64'd1);

    // sw x5,8(x6) then beq x0,x0,-4
    applyStimulus(1, 32'h00532423, 64'h104, 1, 0);
    checkVal("sw_imm", out_imm64, 64'd8);
    checkVal("sw_rs2", 64'(out_rs2_64), 64'd5);
    applyStimulus(1, 32'hFE000EE3, 64'h108, 1, 0);
    checkVal("beq_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    checkVal("beq_fmt", 64'(out_fmt64), 64'd3);

    // jal x1,+2048 then lui x3,0x80000
    applyStimulus(1, 32'h001000EF, 64'h10C, 1, 0);
    checkVal("jal_imm", out_imm64, 64'h800);
    applyStimulus(1, 32'h800001B7, 64'h110, 1, 0);
    checkVal("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    checkVal("lui_imm32", 64'(out_imm32), 64'h8000_0000);
    applyStimulus(0, 32'h0, 64'h0, 1, 0);

    // Backpressure: pcs 0x0, 0x4, 0x8 with out_ready low
    applyStimulus(1, 32'h00000013, 64'h0, 0, 0);
    applyStimulus(1, 32'h00000013, 64'h4, 0, 0);
    checkVal("bp_in_ready_full", 64'(in_ready64), 64'd0);
    applyStimulus(1, 32'h00000013, 64'h8, 0, 0);
    sent = 1'b0;
    for (int c = 0; c < 10 && !sent; c++) begin
      applyStimulus(1, 32'h00000013, 64'h8, 1, 0);
      sent = lastAcc;
    end
    checkVal("bp_third_accepted", 64'(sent), 64'd1);
    for (int c = 0; c < 3; c++) applyStimulus(0, 32'h0, 64'h0, 1, 0);

    // Flush while FULL with a same-cycle input
    applyStimulus(1, 32'h00000013, 64'h40, 0, 0);
    applyStimulus(1, 32'h00000013, 64'h44, 0, 0);
    applyStimulus(1, 32'h00000013, 64'h48, 0, 1);
    checkVal("flush_out_valid", 64'(out_valid64), 64'd0);
    checkVal("flush_in_ready", 64'(in_ready64), 64'd1);
    for (int c = 0; c < 2; c++) applyStimulus(0, 32'h0, 64'h0, 1, 0);

    // Illegal encodings and a legal jal-like word
    applyStimulus(1, 32'h00000000, 64'h200, 1, 0);
    checkVal("zero_illegal", 64'(out_illegal64), 64'd1);
    checkVal("zero_fmt", 64'(out_fmt64), 64'd7);
    applyStimulus(1, 32'h0000706F, 64'h204, 1, 0);
    checkVal("jal706f_illegal", 64'(out_illegal64), 64'd0);
    applyStimulus(1, 32'h00001067, 64'h208, 1, 0);
    checkVal("jalr_f3_illegal", 64'(out_illegal64), 64'd1);
    applyStimulus(0, 32'h0, 64'h0, 1, 0);

    // Asynchronous reset pulse while holding two instructions
    applyStimulus(1, 32'h00000013, 64'h300, 0, 0);
    applyStimulus(1, 32'h00000013, 64'h304, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checkVal("arst_out_valid", 64'(out_valid64), 64'd0);
    checkVal("arst_in_ready", 64'(in_ready64), 64'd1);
    checkVal("arst_out_pc", out_pc64, 64'd0);
    q.delete();
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      r   = $urandom();
      sel = $urandom_range(0, 11);
      if (sel < 10) ins = {r[31:7], ops[sel]};
      else          ins = r;
      if (sel == 9) ins[31:25] = r[0] ? 7'h20 : 7'h00;
      applyStimulus(1'($urandom_range(0, 3) != 0), ins,
                    {$urandom(), $urandom()} & ~64'd3,
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 24) == 0));
    end
    for (int c = 0; c < 3; c++) applyStimulus(0, 32'h0, 64'h0, 1, 0);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Sits between fetch and register-read/execute.
- Splits the instruction into fields, generates the fully sign-extended immediate for every format and classifies the format.
- Flags illegal encodings and supports a pipeline flush.
- Every output field is defined for every opcode; unused fields read zero.

Parameters:
- XLEN, 32, datapath width of imm and pc (legal values 32 or 64).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all held instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream consumes the output.
- out_pc  out  XLEN  pc of the output instruction.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  destination register; 0 for S and B formats.
- out_rs1  out  5  source register 1; 0 for U and J formats.
- out_rs2  out  5  source register 2; 0 unless R, S or B format.
- out_funct3  out  3  instr[14:12]; 0 for U and J formats.
- out_funct7  out  7  instr[31:25] for R format, else 0.
- out_imm  out  XLEN  sign-extended immediate; 0 for R format.
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=invalid.
- out_illegal  out  1  illegal encoding.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is EMPTY.
  - out_valid and all out_* fields are 0.
  - in_ready is 1.
- Handshakes:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (state != FULL), driven from registered state only and never from in_valid or out_ready.
- Decode is combinational on in_instr. Results are captured into the main register or the skid register.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 when the main register is free.
- Output data is held stable while out_valid=1 and out_ready=0.
- State machine:
  - EMPTY: acc -> ONE; main loads the decoded input.
  - ONE, acc & !pop -> FULL; skid loads the decoded input.
  - ONE, acc & pop -> ONE; main loads the decoded input.
  - ONE, !acc & pop -> EMPTY.
  - FULL, pop -> ONE; main loads from skid. No acc is possible in FULL.
- Order is strictly FIFO. No instruction is lost or duplicated.
- out_valid = (state != EMPTY).
- Flush:
  - flush=1 forces EMPTY on the next edge and clears out_valid.
  - Flush has priority over a same-cycle acc; that input is dropped and fetch must treat it as consumed.
  - in_ready is 1 in the following cycle.
- Opcode to format mapping:
  - 0110011 -> R.
  - 0000011, 0010011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Anything else -> invalid (fmt 7).
- Immediates, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Illegal conditions (any one sets out_illegal=1):
  - instr[1:0] != 2'b11.
  - Format invalid.
  - R format with funct7 not 0000000 or 0100000.
  - JALR with funct3 != 0.
  - B format with funct3 of 010 or 011.
- When out_illegal=1: out_fmt=7, rd/rs1/rs2/imm are 0, and out_opcode and out_pc are still valid.
- Never a latch: every output is assigned in every path.

Test Plan:
1. addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, funct3=0, fmt=1, imm=0xFFFFFFFF, rs2=0.
2. sw x5,8(x6) (0x00532423); beq x0,x0,-4 (0xFE000EE3) -> S: rs1=6, rs2=5, rd=0, imm=8, fmt=2; then B: imm=0xFFFFFFFC, fmt=3.
3. jal x1,+2048 (0x001000EF) -> rd=1, imm=0x00000800, fmt=5. lui x3,0x80000 (0x800001B7) with XLEN=64 -> imm=0xFFFFFFFF80000000, fmt=4.
4. Backpressure: out_ready=0, in_valid=1 with pcs 0x0, 0x4, 0x8 -> first two accepted, in_ready=0 from the cycle after the second. Then out_ready=1 -> outputs in pc order 0x0, 0x4, 0x8, no gaps, no duplicates.
5. Flush while FULL with in_valid=1 in the same cycle -> next cycle out_valid=0 and in_ready=1; the flushed and same-cycle instructions never appear on the output.
6. 0x00000000 and 0x0000706F (jal-like opcode 1101111 with low bits ok -> legal) vs 0x00001067 (jalr funct3=1) -> 0x00000000 illegal, fmt=7; 0x00001067 illegal; async rst_n pulse mid-stream -> out_valid drops immediately, without waiting for a clock edge.
